// File: rtl/ltc_spi_responder_pkg.sv
// ============================================================================
// ltc_resp_pkg: opcodes, register map, status layout and FSM states for the
// LTC SPI responder.                                              Rev 1.0
// ============================================================================
`default_nettype none

package ltc_resp_pkg;

  localparam logic [7:0]  c_op_write        = 8'h02;
  localparam logic [7:0]  c_op_read         = 8'h03;

  localparam logic [15:0] c_addr_status     = 16'h0000;
  localparam logic [15:0] c_addr_result     = 16'h0010;
  localparam logic [15:0] c_addr_result_end = 16'h005F;
  localparam logic [15:0] c_addr_cfg        = 16'h0200;
  localparam logic [15:0] c_addr_cfg_end    = 16'h023F;
  localparam int          c_cfg_depth       = 64;

  localparam int          c_stat_start      = 7;
  localparam int          c_stat_done       = 6;
  localparam logic [7:0]  c_status_reset    = 8'h40;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INSTR,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_WRITE,
    ST_READ,
    ST_IGNORE
  } state_t;

  function automatic logic [7:0] status_word(input logic start, input logic done,
                                             input logic [4:0] ch);
    logic [7:0] s;
    s               = 8'h00;
    s[c_stat_start] = start;
    s[c_stat_done]  = done;
    s[4:0]          = ch;
    return s;
  endfunction

  function automatic logic in_cfg(input logic [15:0] a);
    return (a >= c_addr_cfg) && (a <= c_addr_cfg_end);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ltc_spi_responder_if.sv
// ============================================================================
// ltc_spi_responder_if: mode-0 SPI bus between a host and the responder.
//                                                                 Rev 1.0
// ============================================================================
`default_nettype none

interface ltc_spi_responder_if;
  logic sck;
  logic cs_n;
  logic mosi;
  logic miso;

  modport master (output sck, output cs_n, output mosi, input miso);
  modport slave  (input sck, input cs_n, input mosi, output miso);
endinterface

`default_nettype wire

// File: rtl/ltc_spi_responder_shifter.sv
// ============================================================================
// spi_slave_shifter: synchronizes the SPI pins into clk, frames bytes and
// shifts the transmit byte out on sck falling edges.              Rev 1.0
// ============================================================================
`default_nettype none

module spi_slave_shifter (
  input  logic       clk,
  input  logic       reset1,
  input  logic       sck,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       cs_fall,
  output logic       cs_rise,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  input  logic       tx_load,
  input  logic [7:0] tx_byte
);

  logic [2:0] r_sck;
  logic [2:0] r_cs;
  logic [1:0] r_mosi;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_rx_shift;
  logic [7:0] r_tx_shift;
  logic       w_sck_rise;
  logic       w_sck_fall;
  logic       w_cs_active;

  // Bit [1] is the synchronized level, bit [2] its previous value.
  assign w_sck_rise  =  r_sck[1] & ~r_sck[2];
  assign w_sck_fall  = ~r_sck[1] &  r_sck[2];
  assign cs_fall     = ~r_cs[1]  &  r_cs[2];
  assign cs_rise     =  r_cs[1]  & ~r_cs[2];
  assign w_cs_active = ~r_cs[1];

  always_ff @(posedge clk or negedge reset1) begin
    if (!reset1) begin
      r_sck      <= 3'b000;
      r_cs       <= 3'b111;
      r_mosi     <= 2'b00;
      r_bit_cnt  <= 3'd0;
      r_rx_shift <= 8'h00;
      r_tx_shift <= 8'h00;
      rx_byte    <= 8'h00;
      byte_valid <= 1'b0;
      miso       <= 1'b0;
    end else begin
      r_sck      <= {r_sck[1:0], sck};
      r_cs       <= {r_cs[1:0], cs_n};
      r_mosi     <= {r_mosi[0], mosi};
      byte_valid <= 1'b0;
      if (!w_cs_active) begin
        // Deselect drops any partial byte and silences miso.
        r_bit_cnt  <= 3'd0;
        r_rx_shift <= 8'h00;
        r_tx_shift <= 8'h00;
        miso       <= 1'b0;
      end else begin
        if (w_sck_rise) begin
          r_rx_shift <= {r_rx_shift[6:0], r_mosi[1]};
          r_bit_cnt  <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            byte_valid <= 1'b1;
            rx_byte    <= {r_rx_shift[6:0], r_mosi[1]};
          end
        end
        if (w_sck_fall) begin
          miso       <= r_tx_shift[7];
          r_tx_shift <= {r_tx_shift[6:0], 1'b0};
        end
        if (tx_load) begin
          r_tx_shift <= tx_byte;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ltc_spi_responder.sv
// ============================================================================
// ltc_spi_responder: SPI register responder with config RAM and temperature
// conversion control. Optional intr output: LTC_RESP_INTERRUPT_EN. Rev 1.0
// ============================================================================
`default_nettype none

module ltc_spi_responder
  import ltc_resp_pkg::*;
#(
  parameter int CONV_CYCLES = 1000,
  parameter int NUM_CH      = 20
) (
  input  logic                 clk,
  input  logic                 reset1,
  ltc_spi_responder_if.slave   spi,
  input  logic [23:0]          result_value,
  output logic                 conv_busy
`ifdef LTC_RESP_INTERRUPT_EN
  ,
  output logic                 intr
`endif
);

  localparam int CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

  logic             cs_fall;
  logic             cs_rise;
  logic             byte_valid;
  logic [7:0]       rx_byte;
  logic [7:0]       tx_byte;

  state_t           r_state;
  logic [7:0]       r_instr;
  logic [15:0]      r_addr;
  logic [7:0]       r_status;
  logic [23:0]      r_result;
  logic [4:0]       r_last_ch;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_cfg [c_cfg_depth];

  logic [15:0]      w_rd_addr;
  logic [15:0]      w_res_off;
  logic [7:0]       w_rd_data;
  logic             w_to_read;
  logic             w_wr_en;
  logic [4:0]       w_wr_ch;
  logic             w_ch_ok;

  spi_slave_shifter u_shifter (
    .clk        (clk),
    .reset1     (reset1),
    .sck        (spi.sck),
    .cs_n       (spi.cs_n),
    .mosi       (spi.mosi),
    .miso       (spi.miso),
    .cs_fall    (cs_fall),
    .cs_rise    (cs_rise),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .tx_load    (byte_valid),
    .tx_byte    (tx_byte)
  );

  // The byte loaded at the end of one byte is the one for the next address.
  always_comb begin
    w_to_read = ((r_state == ST_ADDR_L) && (r_instr == c_op_read)) || (r_state == ST_READ);
    w_rd_addr = (r_state == ST_ADDR_L) ? {r_addr[15:8], rx_byte} : r_addr + 16'd1;
    w_res_off = w_rd_addr - c_addr_result;
    w_rd_data = 8'h00;
    if (w_rd_addr == c_addr_status) begin
      w_rd_data = r_status;
    end else if (in_cfg(w_rd_addr)) begin
      w_rd_data = r_cfg[w_rd_addr[5:0]];
    end else if ((w_rd_addr >= c_addr_result) && (w_rd_addr <= c_addr_result_end) &&
                 (r_last_ch != 5'd0) &&
                 (w_res_off[15:2] == {9'd0, r_last_ch - 5'd1})) begin
      case (w_res_off[1:0])
        2'd0:    w_rd_data = 8'h01;
        2'd1:    w_rd_data = r_result[23:16];
        2'd2:    w_rd_data = r_result[15:8];
        default: w_rd_data = r_result[7:0];
      endcase
    end
    tx_byte = w_to_read ? w_rd_data : 8'h00;
    w_wr_en = byte_valid && (r_state == ST_WRITE);
    w_wr_ch = rx_byte[4:0];
    w_ch_ok = (w_wr_ch != 5'd0) && (int'(w_wr_ch) <= NUM_CH);
  end

  always_ff @(posedge clk or negedge reset1) begin
    if (!reset1) begin
      r_state <= ST_IDLE;
      r_instr <= 8'h00;
      r_addr  <= 16'h0000;
    end else if (cs_rise) begin
      r_state <= ST_IDLE;
    end else if (cs_fall) begin
      r_state <= ST_INSTR;
    end else if (byte_valid) begin
      case (r_state)
        ST_INSTR: begin
          r_instr <= rx_byte;
          r_state <= ((rx_byte == c_op_write) || (rx_byte == c_op_read)) ? ST_ADDR_H : ST_IGNORE;
        end
        ST_ADDR_H: begin
          r_addr[15:8] <= rx_byte;
          r_state      <= ST_ADDR_L;
        end
        ST_ADDR_L: begin
          r_addr[7:0] <= rx_byte;
          r_state     <= (r_instr == c_op_write) ? ST_WRITE : ST_READ;
        end
        ST_WRITE, ST_READ: r_addr <= r_addr + 16'd1;
        default:           r_state <= r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset1) begin
    if (!reset1) begin
      r_status  <= c_status_reset;
      conv_busy <= 1'b0;
      r_result  <= 24'h000000;
      r_last_ch <= 5'd0;
      r_cnt     <= '0;
      for (int i = 0; i < c_cfg_depth; i++) begin
        r_cfg[i] <= 8'h00;
      end
    end else begin
      if (conv_busy) begin
        if (r_cnt == CNT_W'(CONV_CYCLES - 1)) begin
          r_result  <= result_value;
          r_last_ch <= r_status[4:0];
          r_status  <= status_word(1'b0, 1'b1, r_status[4:0]);
          conv_busy <= 1'b0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      if (w_wr_en) begin
        if (r_addr == c_addr_status) begin
          if (!conv_busy && rx_byte[c_stat_start]) begin
            if (w_ch_ok) begin
              r_status  <= status_word(1'b1, 1'b0, w_wr_ch);
              conv_busy <= 1'b1;
              r_cnt     <= '0;
            end else begin
              r_status <= status_word(1'b0, 1'b1, w_wr_ch);
            end
          end
        end else if (in_cfg(r_addr)) begin
          r_cfg[r_addr[5:0]] <= rx_byte;
        end
      end
    end
  end

`ifdef LTC_RESP_INTERRUPT_EN
  assign intr = r_status[c_stat_done];
`endif

endmodule

`default_nettype wire
